// File: rtl/dcache_scrub_scheduler.sv
// Purpose: background SECDED scrub walk sharing the data-cache SRAM port with foreground traffic.
// Latency: read grant at T, ECC verdict sampled at T+1, earliest writeback grant at T+2.
// Backpressure: foreground wins the port unless the scrubber has been denied STARVE_LIMIT cycles.
module dcache_scrub_scheduler #(
  parameter int NUM_WAYS     = 8,
  parameter int INDEX_W      = 8,
  parameter int INTERVAL_W   = 16,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [INTERVAL_W-1:0]    interval_i,
  input  logic                     fg_req_i,
  input  logic                     fg_we_i,
  input  logic [INDEX_W-1:0]       fg_idx_i,
  output logic                     fg_gnt_o,
  output logic                     scrub_req_o,
  output logic                     scrub_we_o,
  output logic [INDEX_W-1:0]       scrub_idx_o,
  output logic [NUM_WAYS-1:0]      scrub_way_o,
  input  logic [NUM_WAYS-1:0][1:0] ecc_err_i,
  output logic                     scrub_done_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         corr_cnt_o,
  output logic [CNT_W-1:0]         uncorr_cnt_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int PC_W     = $clog2(NUM_WAYS + 1);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0]   STARVE_ONE = STARVE_W'(1);
  localparam logic [INTERVAL_W-1:0] IVL_ONE    = INTERVAL_W'(1);
  localparam logic [INDEX_W-1:0]    IDX_ONE    = INDEX_W'(1);

  typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

  state_t                state, state_nxt;
  logic [INTERVAL_W-1:0] ivl_cnt;
  logic [INTERVAL_W-1:0] ivl_eff;
  logic                  ivl_hit;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  forced;
  logic                  grant;
  logic                  advance;
  logic [NUM_WAYS-1:0]   corr_mask;
  logic [NUM_WAYS-1:0]   corr_now;
  logic [NUM_WAYS-1:0]   uncorr_now;
  logic [PC_W-1:0]       corr_pc;
  logic [PC_W-1:0]       uncorr_pc;

  // Saturating accumulate of a per-set way count into a statistics counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - PC_W){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Interval compare (0 behaves as 1), forced grant and ECC verdict decode.
  always_comb begin
    ivl_eff    = (interval_i == '0) ? IVL_ONE : interval_i;
    ivl_hit    = (ivl_cnt >= (ivl_eff - IVL_ONE));
    forced     = (starve_cnt == STARVE_MAX);
    grant      = ~fg_req_i | forced;
    corr_now   = '0;
    uncorr_now = '0;
    corr_pc    = '0;
    uncorr_pc  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      corr_now[w]   = ecc_err_i[w][0] & ~ecc_err_i[w][1];
      uncorr_now[w] = ecc_err_i[w][1];
      corr_pc       = corr_pc + PC_W'(corr_now[w]);
      uncorr_pc     = uncorr_pc + PC_W'(uncorr_now[w]);
    end
  end

  // Next-state logic and port-ownership outputs.
  always_comb begin
    state_nxt   = state;
    fg_gnt_o    = fg_req_i;
    scrub_req_o = 1'b0;
    scrub_we_o  = 1'b0;
    scrub_way_o = '0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (en_i && ivl_hit) state_nxt = READ;
      end
      READ: begin
        fg_gnt_o    = fg_req_i & ~forced;
        scrub_way_o = '1;
        if (grant) begin
          scrub_req_o = 1'b1;
          state_nxt   = CHECK;
        end else if (!en_i) begin
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (|corr_now) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = IDLE;
          advance   = 1'b1;
        end
      end
      WRITE: begin
        fg_gnt_o    = fg_req_i & ~forced;
        scrub_we_o  = 1'b1;
        scrub_way_o = corr_mask;
        if (grant) begin
          scrub_req_o = 1'b1;
          state_nxt   = IDLE;
          advance     = 1'b1;
        end else if (fg_we_i && (fg_idx_i == scrub_idx_o)) begin
          // Denied here means foreground holds the port; its write to this set
          // already refreshed the line, so re-read instead of writing stale data.
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Interval timer: runs only while enabled in IDLE, restarts on every launch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                 ivl_cnt <= '0;
    else if (state == IDLE && en_i && !ivl_hit) ivl_cnt <= ivl_cnt + IVL_ONE;
    else                                         ivl_cnt <= '0;
  end

  // Starve counter: counts denied scrub cycles, saturating at the forced-grant level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                                   starve_cnt <= '0;
    else if ((state == READ || state == WRITE) && !grant && !forced) starve_cnt <= starve_cnt + STARVE_ONE;
    else if ((state == READ || state == WRITE) && !grant)            starve_cnt <= starve_cnt;
    else                                                           starve_cnt <= '0;
  end

  // Correctable-way mask and error statistics captured in CHECK.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      corr_mask    <= '0;
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else if (state == CHECK) begin
      corr_mask    <= corr_now;
      corr_cnt_o   <= sat_add(corr_cnt_o, corr_pc);
      uncorr_cnt_o <= sat_add(uncorr_cnt_o, uncorr_pc);
    end
  end

  // Scrub index walk and wrap pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scrub_idx_o  <= '0;
      scrub_done_o <= 1'b0;
    end else begin
      scrub_done_o <= advance && (scrub_idx_o == '1);
      if (advance) scrub_idx_o <= scrub_idx_o + IDX_ONE;
    end
  end

endmodule
